// File: rtl/sdr_init_refresh_sched.sv
// SDRAM power-up initialisation and periodic refresh scheduler; owns the command bus until init completes.
// Optional SDR_INIT_FAST_EN shortens the power-up wait to 16 cycles for simulation.
module sdr_init_refresh_sched #(
    parameter int          PWRUP_CYC    = 20000,
    parameter int          TRP          = 3,
    parameter int          TRFC         = 7,
    parameter int          TMRD         = 2,
    parameter int          INIT_REF     = 8,
    parameter int          REF_INT      = 780,
    parameter int          REF_DEBT_MAX = 8,
    parameter logic [12:0] MODE_REG     = 13'h033
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic        ref_gnt,
    output logic        ref_req,
    output logic        cmd_own,
    output logic        sdr_cke,
    output logic        sdr_cs_n,
    output logic        sdr_ras_n,
    output logic        sdr_cas_n,
    output logic        sdr_we_n,
    output logic [1:0]  sdr_ba,
    output logic [12:0] sdr_addr,
    output logic        sdr_init_done,
    output logic [3:0]  ref_debt,
    output logic        ref_overflow
);

`ifdef SDR_INIT_FAST_EN
    localparam int PWRUP_WAIT = 16;
`else
    localparam int PWRUP_WAIT = PWRUP_CYC;
`endif

    localparam int CNT_W  = $clog2(PWRUP_WAIT + TRP + TRFC + TMRD + 2);
    localparam int TMR_W  = (REF_INT > 1) ? $clog2(REF_INT) : 1;
    localparam int AREF_W = $clog2(INIT_REF + 1);

    localparam logic [CNT_W-1:0]  PWRUP_LAST = CNT_W'(PWRUP_WAIT);
    localparam logic [CNT_W-1:0]  TRP_C      = CNT_W'(TRP);
    localparam logic [CNT_W-1:0]  TRFC_C     = CNT_W'(TRFC);
    localparam logic [CNT_W-1:0]  TMRD_C     = CNT_W'(TMRD);
    localparam logic [AREF_W-1:0] INIT_REF_C = AREF_W'(INIT_REF);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(REF_INT - 1);
    localparam logic [3:0]        DEBT_MAX   = 4'(REF_DEBT_MAX);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_PRE,
        ST_WAIT_TRP,
        ST_AREF,
        ST_WAIT_TRFC,
        ST_LMR,
        ST_WAIT_TMRD,
        ST_IDLE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [AREF_W-1:0]   aref_cnt, aref_cnt_nxt;
    logic [TMR_W-1:0]    timer;
    logic [3:0]          cmd_nxt;
    logic [12:0]         addr_nxt;
    logic [3:0]          debt_nxt;
    logic                ovf_set;
    logic                credit;
    logic                take;

    // Each command state lasts one cycle; cnt counts cycles since the last command was issued.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        aref_cnt_nxt = aref_cnt;
        case (state)
            ST_PWRUP: begin
                if (cnt == PWRUP_LAST) begin
                    state_nxt = ST_PRE;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_PRE, ST_WAIT_TRP: begin
                if (cnt == TRP_C) begin
                    state_nxt = ST_AREF;
                    cnt_nxt   = CNT_W'(1);
                    if (!sdr_init_done)
                        aref_cnt_nxt = aref_cnt + 1'b1;
                end else begin
                    state_nxt = ST_WAIT_TRP;
                end
            end
            ST_AREF, ST_WAIT_TRFC: begin
                if (cnt == TRFC_C) begin
                    cnt_nxt = CNT_W'(1);
                    if (sdr_init_done) begin
                        state_nxt = ST_IDLE;
                    end else if (aref_cnt < INIT_REF_C) begin
                        state_nxt    = ST_AREF;
                        aref_cnt_nxt = aref_cnt + 1'b1;
                    end else begin
                        state_nxt = ST_LMR;
                    end
                end else begin
                    state_nxt = ST_WAIT_TRFC;
                end
            end
            ST_LMR, ST_WAIT_TMRD: begin
                if (cnt == TMRD_C) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_WAIT_TMRD;
                end
            end
            ST_IDLE: begin
                cnt_nxt = '0;
                if (ref_req && ref_gnt) begin
                    state_nxt = ST_PRE;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_PWRUP;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Command outputs are registered from the next state so the bus never glitches.
    always_comb begin
        cmd_nxt  = CMD_NOP;
        addr_nxt = '0;
        case (state_nxt)
            ST_PRE: begin
                cmd_nxt      = CMD_PRE;
                addr_nxt[10] = 1'b1;
            end
            ST_AREF: cmd_nxt = CMD_AREF;
            ST_LMR: begin
                cmd_nxt  = CMD_LMR;
                addr_nxt = MODE_REG;
            end
            default: ;
        endcase
    end

    // A credit coinciding with a refresh cancels out, so it is only lost when debt is saturated.
    always_comb begin
        credit   = sdr_init_done && (timer == TMR_LAST);
        take     = sdr_init_done && (state_nxt == ST_AREF);
        debt_nxt = ref_debt;
        ovf_set  = 1'b0;
        if (credit && !take) begin
            if (ref_debt == DEBT_MAX)
                ovf_set = 1'b1;
            else
                debt_nxt = ref_debt + 1'b1;
        end else if (take && !credit) begin
            debt_nxt = ref_debt - 1'b1;
        end
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state         <= ST_PWRUP;
            cnt           <= '0;
            aref_cnt      <= '0;
            timer         <= '0;
            sdr_cke       <= 1'b0;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= 4'b1111;
            sdr_ba        <= 2'b00;
            sdr_addr      <= '0;
            cmd_own       <= 1'b1;
            ref_req       <= 1'b0;
            sdr_init_done <= 1'b0;
            ref_debt      <= '0;
            ref_overflow  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            aref_cnt      <= aref_cnt_nxt;
            sdr_cke       <= 1'b1;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd_nxt;
            sdr_ba        <= 2'b00;
            sdr_addr      <= addr_nxt;
            cmd_own       <= (state_nxt != ST_IDLE);
            ref_req       <= (state == ST_IDLE) && (ref_debt != 4'd0) && !(ref_req && ref_gnt);
            sdr_init_done <= sdr_init_done || (state_nxt == ST_IDLE);
            ref_debt      <= debt_nxt;
            ref_overflow  <= ref_overflow || ovf_set;
            if (sdr_init_done)
                timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
        end
    end

endmodule
